// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first; valid pulse ~9.5 bit times after the start edge (+2 sync, +1 reg).
// No backpressure: rx_data must be taken on the rx_valid pulse, the next good byte overwrites it.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [15:0] counter, counter_nxt;
  logic [2:0]  bit_index, bit_index_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  rx_data_nxt;
  logic        rx_valid_nxt, frame_err_nxt;
  logic        rx_meta, rx_s;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      counter   <= '0;
      bit_index <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_nxt;
      counter   <= counter_nxt;
      bit_index <= bit_index_nxt;
      shift     <= shift_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
      // Derived from the next state so busy lines up with the state register.
      rx_busy   <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt     = state;
    counter_nxt   = counter;
    bit_index_nxt = bit_index;
    shift_nxt     = shift;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          counter_nxt = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a short low pulse is treated as a glitch.
        if (counter == HALF) begin
          if (!rx_s) begin
            state_nxt     = DATA;
            counter_nxt   = '0;
            bit_index_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          counter_nxt = counter + 16'd1;
        end
      end
      DATA: begin
        if (counter == LAST) begin
          shift_nxt[bit_index] = rx_s;
          counter_nxt          = '0;
          if (bit_index == 3'd7) state_nxt = STOP;
          else                   bit_index_nxt = bit_index + 3'd1;
        end else begin
          counter_nxt = counter + 16'd1;
        end
      end
      STOP: begin
        if (counter == LAST) begin
          counter_nxt = '0;
          if (rx_s) begin
            rx_data_nxt  = shift;
            rx_valid_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          counter_nxt = counter + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not decoded as a stream of 0x00 frames.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
